// File: rtl/palette_pkg.sv
// Shared types and helpers for the double-buffered video palette:
// FSM encoding, default colour set, index width and brightness scaling.
package palette_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2
    } state_t;

    // 12-bit RGB (4 bits per component, R most significant), entry 0 lowest.
    localparam logic [15:0][11:0] DEFAULT_PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
        12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hF1F, 12'hA00,
        12'h0AA, 12'h0A0, 12'h00A, 12'h111
    };

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Entry idx of the 16-colour set, each 4-bit component truncated (keep MSBs)
    // or zero-padded on the right to comp_w bits.
    function automatic logic [15:0] init_entry(input logic [15:0][11:0] pal,
                                               input int idx, input int comp_w);
        logic [15:0] res;
        logic [15:0] v;
        logic [3:0]  n;
        res = '0;
        for (int c = 2; c >= 0; c--) begin
            n = pal[idx % 16][c*4 +: 4];
            if (comp_w <= 4)
                v = 16'(n >> (4 - comp_w));
            else
                v = 16'(n) << (comp_w - 4);
            res = (res << comp_w) | v;
        end
        return res;
    endfunction

    // comp * (bright + 1) / 16; bright = 15 is unity gain.
    function automatic logic [4:0] scale_comp(input logic [4:0] comp, input logic [3:0] bright);
        logic [9:0] prod;
        prod = 10'(comp) * 10'({1'b0, bright} + 5'd1);
        return 5'(prod >> 4);
    endfunction

endpackage

// File: rtl/palette_bank.sv
// Palette storage: one synchronous write port, two asynchronous read ports.
// Contents come from the default set at configuration and are never reset.
module palette_bank
    import palette_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int COMP_W  = 4,
    parameter logic [15:0][11:0] PALETTE_INIT = DEFAULT_PALETTE,
    localparam int IDX_W = idx_w(ENTRIES),
    localparam int W     = 3 * COMP_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [W-1:0]     rdata_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [W-1:0]     rdata_b
);

    typedef logic [W-1:0] mem_t [ENTRIES];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < ENTRIES; i++)
            m[i] = W'(init_entry(PALETTE_INIT, i, COMP_W));
        return m;
    endfunction

    mem_t mem = init_mem();

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/palette_dbuf.sv
// Double-buffered palette: CPU edits the shadow bank, a commit engine copies it
// into the active bank (at vblank or at once), video reads active through a scaler.
module palette_dbuf
    import palette_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int COMP_W  = 4,
    parameter logic [15:0][11:0] PALETTE_INIT = DEFAULT_PALETTE,
    localparam int IDX_W = idx_w(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  addr,
    input  logic [15:0]       wrdata,
    input  logic              wren,
    output logic [15:0]       rddata,
    input  logic              commit_req,
    input  logic              sync_mode,
    input  logic              vblank_start,
    output logic              busy,
    input  logic [3:0]        bright,
    input  logic              pix_valid,
    input  logic [IDX_W-1:0]  palidx,
    output logic [COMP_W-1:0] pal_r,
    output logic [COMP_W-1:0] pal_g,
    output logic [COMP_W-1:0] pal_b,
    output logic              pal_valid,
    output logic [1:0]        dbg_state,
    output logic [IDX_W-1:0]  dbg_copy_idx,
    output logic              dbg_pending,
    output logic [15:0]       dbg_active
);

    localparam int CW = 3 * COMP_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    state_t           state;
    logic [IDX_W-1:0] copy_idx;
    logic             pending;
    logic             pend_sync;
    logic [CW-1:0]    shadow_rd;
    logic [CW-1:0]    shadow_copy;
    logic [CW-1:0]    active_rd;
    logic [CW-1:0]    active_dbg;
    logic             pend_now;
    logic             pend_mode;
    logic             unused_bits;

    palette_bank #(.ENTRIES(ENTRIES), .COMP_W(COMP_W), .PALETTE_INIT(PALETTE_INIT)) u_shadow (
        .clk     (clk),
        .we      (wren),
        .waddr   (addr),
        .wdata   (wrdata[CW-1:0]),
        .raddr_a (addr),
        .rdata_a (shadow_rd),
        .raddr_b (copy_idx),
        .rdata_b (shadow_copy)
    );

    // Shadow is read combinationally, so a CPU write to the entry being copied
    // this cycle lands after the copy: active receives the old value.
    palette_bank #(.ENTRIES(ENTRIES), .COMP_W(COMP_W), .PALETTE_INIT(PALETTE_INIT)) u_active (
        .clk     (clk),
        .we      (state == ST_COPY),
        .waddr   (copy_idx),
        .wdata   (shadow_copy),
        .raddr_a (palidx),
        .rdata_a (active_rd),
        .raddr_b (addr),
        .rdata_b (active_dbg)
    );

    assign rddata     = 16'(shadow_rd);
    assign dbg_active = 16'(active_dbg);
    assign unused_bits = ^wrdata[15:CW];

    // A request arriving on the final copy cycle still chains a new commit.
    assign pend_now  = pending | commit_req;
    assign pend_mode = pending ? pend_sync : sync_mode;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            copy_idx  <= '0;
            pending   <= 1'b0;
            pend_sync <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (commit_req) begin
                        state    <= sync_mode ? ST_ARMED : ST_COPY;
                        copy_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (vblank_start) begin
                        state    <= ST_COPY;
                        copy_idx <= '0;
                    end
                end
                ST_COPY: begin
                    if (copy_idx == LAST_IDX) begin
                        copy_idx <= '0;
                        pending  <= 1'b0;
                        if (pend_now) begin
                            state <= pend_mode ? ST_ARMED : ST_COPY;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        copy_idx <= copy_idx + 1'b1;
                        if (commit_req && !pending) begin
                            pending   <= 1'b1;
                            pend_sync <= sync_mode;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state    = state;
    assign dbg_copy_idx = copy_idx;
    assign dbg_pending  = pending;

    // Video path: pix_valid/pal_valid form a valid-only pipeline (no ready,
    // no stall); one index accepted per cycle, result two cycles later.
    logic          s1_valid;
    logic [CW-1:0] s1_color;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_color  <= '0;
            pal_valid <= 1'b0;
            pal_r     <= '0;
            pal_g     <= '0;
            pal_b     <= '0;
        end else begin
            s1_valid  <= pix_valid;
            s1_color  <= active_rd;
            pal_valid <= s1_valid;
            if (s1_valid) begin
                pal_r <= COMP_W'(scale_comp(5'(s1_color[3*COMP_W-1 -: COMP_W]), bright));
                pal_g <= COMP_W'(scale_comp(5'(s1_color[2*COMP_W-1 -: COMP_W]), bright));
                pal_b <= COMP_W'(scale_comp(5'(s1_color[COMP_W-1 -: COMP_W]), bright));
            end else begin
                pal_r <= '0;
                pal_g <= '0;
                pal_b <= '0;
            end
        end
    end

endmodule
